// File: rtl/lcd_string_writer.sv
// Writes an N_CHARS string to an HD44780-style 8-bit bus, most significant character first,
// once the LCD init sequencer reports Inicializado. Optional macro LCD_WRITER_HOME_EN adds a leading DDRAM-home command.
module lcd_string_writer #(
    parameter int N_CHARS = 9,
    parameter int CNT_W   = 28,
    parameter int T_INIT  = 90000000,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 25,
    parameter int T_CHAR  = 20000000
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Inicializado,
    input  logic                         Start,
    input  logic [8*N_CHARS-1:0]         Entrada,
    output logic                         Enable,
    output logic                         RS,
    output logic                         RW,
    output logic [7:0]                   Dados,
    output logic                         Busy,
    output logic                         Done,
    output logic [$clog2(N_CHARS+1)-1:0] Indice
);

    localparam int IW = $clog2(N_CHARS + 1);

`ifdef LCD_WRITER_HOME_EN
    localparam bit HOME_EN = 1'b1;
`else
    localparam bit HOME_EN = 1'b0;
`endif

    // Every delay must be representable in the shared counter
    if ((64'(T_INIT) >> CNT_W) != 0 || (64'(T_SETUP) >> CNT_W) != 0 ||
        (64'(T_PULSE) >> CNT_W) != 0 || (64'(T_CHAR) >> CNT_W) != 0) begin : g_bad_timing
        $error("lcd_string_writer: a T_* parameter does not fit in CNT_W bits");
    end
    if (N_CHARS < 1 || T_INIT < 1 || T_SETUP < 1 || T_PULSE < 1 || T_CHAR < 1) begin : g_bad_param
        $error("lcd_string_writer: N_CHARS and all T_* must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        SETUP,
        PULSE,
        HOLD,
        FINISH
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic [8*N_CHARS-1:0] str_reg, str_next;
    logic                 home_reg, home_next;

    logic [7:0]           char_arr [N_CHARS];
    logic [7:0]           cur_char;
    logic                 busy_state;
    logic                 data_phase;

    // Character 0 is the most significant byte of the latched string
    for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_chars
        assign char_arr[gi] = str_reg[8*(N_CHARS-gi)-1 -: 8];
    end

    always_comb begin
        cur_char = '0;
        for (int i = 0; i < N_CHARS; i++) begin
            if (idx_reg == IW'(i)) cur_char = char_arr[i];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            str_reg   <= '0;
            home_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            str_reg   <= str_next;
            home_reg  <= home_next;
        end
    end

    assign busy_state = (state_reg == WAIT_INIT) || (state_reg == SETUP) ||
                        (state_reg == PULSE) || (state_reg == HOLD);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        str_next   = str_reg;
        home_next  = home_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (Start && Inicializado && (Entrada != '0)) begin
                    str_next   = Entrada;
                    idx_next   = '0;
                    home_next  = HOME_EN;
                    state_next = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (cnt_reg == CNT_W'(T_INIT - 1)) begin
                    cnt_next   = '0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt_reg == CNT_W'(T_SETUP - 1)) begin
                    cnt_next   = '0;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (cnt_reg == CNT_W'(T_PULSE - 1)) begin
                    cnt_next   = '0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt_reg == CNT_W'(T_CHAR - 1)) begin
                    cnt_next = '0;
                    // The home command leaves Indice at 0 so char 0 follows it
                    if (home_reg) begin
                        home_next  = 1'b0;
                        state_next = SETUP;
                    end else if (idx_reg == IW'(N_CHARS - 1)) begin
                        state_next = FINISH;
                    end else begin
                        idx_next   = idx_reg + IW'(1);
                        state_next = SETUP;
                    end
                end
            end
            FINISH: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
        if (busy_state && !Inicializado) begin
            cnt_next   = '0;
            home_next  = 1'b0;
            state_next = IDLE;
        end
    end

    assign data_phase = (state_reg == SETUP) || (state_reg == PULSE) || (state_reg == HOLD);

    always_comb begin
        Enable = (state_reg == PULSE);
        RS     = data_phase && !home_reg;
        Dados  = '0;
        if (data_phase) Dados = home_reg ? 8'h80 : cur_char;
        RW     = 1'b0;
        Busy   = busy_state;
        Done   = (state_reg == FINISH);
        Indice = idx_reg;
    end

endmodule
